// File: rtl/hazard_pkg.sv
// Shared scoreboard definitions: FSM state encoding and register-file geometry defaults.
package hazard_pkg;

    localparam int unsigned N_REGS_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned CNT_W_DEF  = 2;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StDone  = 2'd2,
        StHold  = 2'd3
    } sb_state_e;

endpackage

// File: rtl/sb_counter.sv
// One per-register pending-write counter; saturates at both ends so it can never wrap.
module sb_counter
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic is_zero,
    output logic is_max,
    output logic zero_next
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc_ok, dec_ok;

    assign is_zero = (cnt_q == '0);
    assign is_max  = &cnt_q;
    assign inc_ok  = inc & ~is_max;
    assign dec_ok  = dec & ~is_zero;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_ok && !dec_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Lets the drain FSM see a final write-back landing in the same cycle.
    assign zero_next = (cnt_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage scoreboard: RAW/WAW-overflow stall generation, drain sequencing and
// a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned N_REGS = N_REGS_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_src1_addr,
    input  logic              id_src1_used,
    input  logic [ADDR_W-1:0] id_src2_addr,
    input  logic              id_src2_used,
    input  logic [ADDR_W-1:0] id_dst_addr,
    input  logic              id_reg_write,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              drain_req,
    output logic              issue,
    output logic              stall,
    output logic [N_REGS-1:0] pending_mask,
    output logic              drain_done,
    output logic              err,
    output logic [PERF_W-1:0] stall_cycles
);

    sb_state_e         state_q, state_d;
    logic              drain_done_q;
    logic              err_q, err_d;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    logic [N_REGS-1:0] is_zero, is_max, zero_next, inc_vec, dec_vec;
    logic              raw, waw_full;

    for (genvar g = 0; g < N_REGS; g++) begin : g_cnt
        assign inc_vec[g] = issue & id_reg_write & (id_dst_addr == ADDR_W'(g));
        assign dec_vec[g] = wb_reg_write & (wb_addr == ADDR_W'(g));

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_vec[g]),
            .dec       (dec_vec[g]),
            .is_zero   (is_zero[g]),
            .is_max    (is_max[g]),
            .zero_next (zero_next[g])
        );
    end

    // Hazards use only the registered counts: a write-back this cycle does not bypass.
    assign raw = (id_src1_used & ~is_zero[id_src1_addr])
               | (id_src2_used & ~is_zero[id_src2_addr]);
    assign waw_full = id_reg_write & is_max[id_dst_addr];

    assign issue = ~rst & id_valid & (state_q == StRun) & ~raw & ~waw_full;
    assign stall = ~rst & id_valid & ~issue;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (drain_req) state_d = StDrain;
            StDrain: if (&zero_next) state_d = StDone;
            StDone:  state_d = drain_req ? StHold : StRun;
            StHold:  if (!drain_req) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    assign err_d = err_q | (wb_reg_write & is_zero[wb_addr]);

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StRun;
            drain_done_q   <= 1'b0;
            err_q          <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            drain_done_q   <= (state_d == StDone);
            err_q          <= err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign pending_mask = ~is_zero;
    assign drain_done   = drain_done_q;
    assign err          = err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: the driver queues per-cycle expectations, a negedge monitor pops and compares.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_src1_used, id_src2_used, id_reg_write, wb_reg_write, drain_req;
    logic [2:0]  id_src1_addr, id_src2_addr, id_dst_addr, wb_addr;
    logic        issue, stall, drain_done, err;
    logic [7:0]  pending_mask;
    logic [15:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src1_addr (id_src1_addr),
        .id_src1_used (id_src1_used),
        .id_src2_addr (id_src2_addr),
        .id_src2_used (id_src2_used),
        .id_dst_addr  (id_dst_addr),
        .id_reg_write (id_reg_write),
        .wb_reg_write (wb_reg_write),
        .wb_addr      (wb_addr),
        .drain_req    (drain_req),
        .issue        (issue),
        .stall        (stall),
        .pending_mask (pending_mask),
        .drain_done   (drain_done),
        .err          (err),
        .stall_cycles (stall_cycles)
    );

    typedef struct {
        string       nm;
        logic        iss;
        logic        stl;
        logic [7:0]  m;
        logic        dn;
        logic        er;
        logic [15:0] pf;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic cmp(input string nm, input string fld, input logic [15:0] act,
                       input logic [15:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s.%s got=%h want=%h", nm, fld, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin : mon
            exp_t e;
            e = q.pop_front();
            cmp(e.nm, "issue", 16'(issue), 16'(e.iss));
            cmp(e.nm, "stall", 16'(stall), 16'(e.stl));
            cmp(e.nm, "pending_mask", 16'(pending_mask), 16'(e.m));
            cmp(e.nm, "drain_done", 16'(drain_done), 16'(e.dn));
            cmp(e.nm, "err", 16'(err), 16'(e.er));
            cmp(e.nm, "stall_cycles", stall_cycles, e.pf);
        end
    end

    task automatic drv(input bit r, input bit v, input int s1, input bit s1u, input int s2,
                       input bit s2u, input int d, input bit rw, input bit wbw, input int wba,
                       input bit dr);
        rst          = r;
        id_valid     = v;
        id_src1_addr = 3'(s1);
        id_src1_used = s1u;
        id_src2_addr = 3'(s2);
        id_src2_used = s2u;
        id_dst_addr  = 3'(d);
        id_reg_write = rw;
        wb_reg_write = wbw;
        wb_addr      = 3'(wba);
        drain_req    = dr;
    endtask

    // Queue what this cycle must show, then advance to just after the next edge.
    task automatic ex(input string nm, input bit iss, input bit stl, input logic [7:0] m,
                      input bit dn, input bit er, input int pf);
        exp_t e;
        e.nm = nm; e.iss = iss; e.stl = stl; e.m = m; e.dn = dn; e.er = er; e.pf = 16'(pf);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drv(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        // Reset holds issue/stall low even with a valid instruction.
        drv(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0); ex("rst_hold",  0, 0, 8'h00, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0); ex("rst_hold2", 0, 0, 8'h00, 0, 0, 0);

        // Back-to-back RAW on R3.
        drv(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0); ex("raw_iss",  1, 0, 8'h00, 0, 0, 0);
        drv(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0); ex("raw_st1",  0, 1, 8'h08, 0, 0, 0);
        drv(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0); ex("raw_st2",  0, 1, 8'h08, 0, 0, 1);
        drv(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0); ex("raw_st3",  0, 1, 8'h08, 0, 0, 2);
        drv(0, 1, 3, 1, 0, 0, 0, 0, 1, 3, 0); ex("raw_wb",   0, 1, 8'h08, 0, 0, 3);
        drv(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0); ex("raw_go",   1, 0, 8'h00, 0, 0, 4);
        idle();                               ex("raw_perf", 0, 0, 8'h00, 0, 0, 4);

        // Simultaneous inc/dec on R2.
        drv(0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0); ex("sim_iss",  1, 0, 8'h00, 0, 0, 4);
        drv(0, 1, 0, 0, 0, 0, 2, 1, 1, 2, 0); ex("sim_both", 1, 0, 8'h04, 0, 0, 4);
        idle();                               ex("sim_keep", 0, 0, 8'h04, 0, 0, 4);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0); ex("sim_wb",   0, 0, 8'h04, 0, 0, 4);
        idle();                               ex("sim_clr",  0, 0, 8'h00, 0, 0, 4);

        // WAW saturation on R5, plus a src2 RAW while it is full.
        drv(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0); ex("waw1",     1, 0, 8'h00, 0, 0, 4);
        drv(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0); ex("waw2",     1, 0, 8'h20, 0, 0, 4);
        drv(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0); ex("waw3",     1, 0, 8'h20, 0, 0, 4);
        drv(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0); ex("waw_full", 0, 1, 8'h20, 0, 0, 4);
        drv(0, 1, 0, 0, 0, 0, 5, 1, 1, 5, 0); ex("waw_wb",   0, 1, 8'h20, 0, 0, 5);
        drv(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0); ex("waw_rel",  1, 0, 8'h20, 0, 0, 6);
        drv(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0); ex("raw_src2", 0, 1, 8'h20, 0, 0, 6);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0); ex("waw_d1",   0, 0, 8'h20, 0, 0, 7);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0); ex("waw_d2",   0, 0, 8'h20, 0, 0, 7);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0); ex("waw_d3",   0, 0, 8'h20, 0, 0, 7);
        idle();                               ex("waw_clr",  0, 0, 8'h00, 0, 0, 7);

        // Spurious write-back to R6.
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0); ex("spur",     0, 0, 8'h00, 0, 0, 7);
        idle();                               ex("err_set",  0, 0, 8'h00, 0, 1, 7);
        idle();                               ex("err_stk",  0, 0, 8'h00, 0, 1, 7);

        // Drain with R1 and R4 in flight; same-cycle decode still accepted.
        drv(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0); ex("drn_i1",   1, 0, 8'h00, 0, 1, 7);
        drv(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0); ex("drn_i2",   1, 0, 8'h02, 0, 1, 7);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1); ex("drn_same", 1, 0, 8'h12, 0, 1, 7);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex("drn_blk",  0, 1, 8'h12, 0, 1, 7);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0); ex("drn_wb1",  0, 1, 8'h12, 0, 1, 8);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 0); ex("drn_wb4",  0, 1, 8'h10, 0, 1, 9);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex("drn_done", 0, 1, 8'h00, 1, 1, 10);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex("drn_run",  1, 0, 8'h00, 0, 1, 11);
        idle();                               ex("drn_once", 0, 0, 8'h00, 0, 1, 11);

        // Reset while draining with R1 pending.
        drv(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0); ex("rd_iss",    1, 0, 8'h00, 0, 1, 11);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); ex("rd_req",    0, 0, 8'h02, 0, 1, 11);
        idle();                               ex("rd_drain",  0, 0, 8'h02, 0, 1, 11);
        drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex("rd_rst",    0, 0, 8'h02, 0, 1, 11);
        drv(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0); ex("rd_after",  1, 0, 8'h00, 0, 0, 0);
        idle();                               ex("rd_nodone", 0, 0, 8'h00, 0, 0, 0);

        // Empty-scoreboard drain with drain_req held through DONE -> HOLD.
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1); ex("hold_req",   1, 0, 8'h00, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1); ex("hold_drain", 0, 1, 8'h00, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1); ex("hold_done",  0, 1, 8'h00, 1, 0, 1);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex("hold_hold",  0, 1, 8'h00, 0, 0, 2);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex("hold_run",   1, 0, 8'h00, 0, 0, 3);
        idle();                               ex("hold_end",   0, 0, 8'h00, 0, 0, 3);

        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue got=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
